// File: rtl/sdram_arbiter.sv
// Two-requester arbiter in front of sdramburst: video has fixed priority, and the
// MMU is forced through after STARVE_LIMIT video grants made while it waited.
module sdram_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] v_address,
  input  logic              v_rw_req,
  input  logic              v_burst_len,
  output logic              v_bursting,
  input  logic [ADDR_W-1:0] m_address,
  input  logic              m_rw_req,
  input  logic              m_rw,
  input  logic [DATA_W-1:0] m_write_data,
  input  logic              m_burst_len,
  output logic              m_bursting,
  output logic [ADDR_W-1:0] sd_address,
  output logic              sd_rw_req,
  output logic              sd_rw,
  output logic [DATA_W-1:0] sd_write_data,
  output logic              sd_burst_len,
  input  logic              sd_bursting,
  output logic              owner_m
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, REQ, BURST, GAP} state_t;

  state_t           state, state_nxt;
  logic             owner_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_nxt;
  logic             owner_req;
  logic             force_m;
  logic             in_xfer;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == CNT_MAX) return c;
    return c + CNT_W'(1);
  endfunction

  assign owner_req = owner_m ? m_rw_req : v_rw_req;
  assign force_m   = m_rw_req && (starve_cnt == CNT_MAX);
  assign in_xfer   = (state == REQ) || (state == BURST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner_m    <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      owner_m    <= owner_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner_m;
    starve_nxt = starve_cnt;
    case (state)
      IDLE: begin
        // Video wins a simultaneous request unless the MMU has waited too long.
        if (force_m || (m_rw_req && !v_rw_req)) begin
          owner_nxt  = 1'b1;
          starve_nxt = '0;
          state_nxt  = REQ;
        end else if (v_rw_req) begin
          owner_nxt = 1'b0;
          state_nxt = REQ;
          if (m_rw_req) starve_nxt = sat_inc(starve_cnt);
        end
      end
      REQ: begin
        if (sd_bursting)     state_nxt = BURST;
        else if (!owner_req) state_nxt = IDLE;
      end
      BURST: begin
        if (!sd_bursting) state_nxt = GAP;
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Steering follows owner_m in every state so the mux never glitches mid-transaction.
  assign sd_rw_req     = in_xfer & owner_req;
  assign sd_address    = owner_m ? m_address : v_address;
  assign sd_burst_len  = owner_m ? m_burst_len : v_burst_len;
  assign sd_rw         = owner_m & m_rw;
  assign sd_write_data = m_write_data;
  assign v_bursting    = sd_bursting & ~owner_m & in_xfer;
  assign m_bursting    = sd_bursting &  owner_m & in_xfer;

endmodule
